// File: rtl/raizing_textram_arb.sv
`default_nettype none
// raizing_textram_arb: shares a single-port text RAM between the 68k bus and the line renderer.
// Optional macro RAIZING_TEXTARB_FAIRNESS_EN bounds how long the CPU can be locked out.
module raizing_textram_arb #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int MAXWAIT = 8
) (
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          REN_REQ,
    input  logic [AW-1:0] REN_ADDR,
    output logic          REN_GNT,
    output logic          REN_VALID,
    output logic [DW-1:0] REN_DATA,
    input  logic          CPU_CS,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_DIN,
    input  logic [1:0]    CPU_DSN,
    output logic [DW-1:0] CPU_DOUT,
    output logic          CPU_ACK,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DIN,
    output logic          RAM_WE,
    output logic [1:0]    RAM_BE,
    input  logic [DW-1:0] RAM_DOUT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    vpipe_q, vpipe_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_we_q, ram_we_d;
    logic [1:0]    ram_be_q, ram_be_d;
    logic          op_we_q, op_we_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic          ack_q, ack_d;
    logic          ren_acc;
    logic          cpu_gnt;

`ifdef RAIZING_TEXTARB_FAIRNESS_EN
    localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

    logic [3:0] wait_q, wait_d;
    logic       cpu_waiting;
    logic       cpu_force;

    assign cpu_waiting = (state_q == S_IDLE) && CPU_CS;
    assign cpu_force   = cpu_waiting && (wait_q == MAXWAIT_C);
    assign ren_acc     = REN_REQ && !cpu_force;
    assign cpu_gnt     = cpu_waiting && (!REN_REQ || cpu_force);

    always_comb begin
        wait_d = wait_q;
        if (cpu_gnt)
            wait_d = 4'd0;
        else if (cpu_waiting && REN_REQ && (wait_q != 4'hF))
            wait_d = wait_q + 4'd1;
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96)
            wait_q <= 4'd0;
        else
            wait_q <= wait_d;
    end
`else
    // MAXWAIT only matters when the fairness counter is built in.
    logic unused_maxwait;
    assign unused_maxwait = ^MAXWAIT;

    assign ren_acc = REN_REQ;
    assign cpu_gnt = (state_q == S_IDLE) && CPU_CS && !REN_REQ;
`endif

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        op_we_d    = op_we_q;
        cpu_dout_d = cpu_dout_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_be_d   = ram_be_q;
        ram_we_d   = 1'b0;
        vpipe_d    = {vpipe_q[0], ren_acc};

        // The renderer and CPU never win the port in the same cycle.
        if (ren_acc) begin
            ram_addr_d = REN_ADDR;
        end else if (cpu_gnt) begin
            ram_addr_d = CPU_ADDR;
            ram_din_d  = CPU_DIN;
            ram_be_d   = ~CPU_DSN;
            ram_we_d   = CPU_WE;
        end

        case (state_q)
            S_IDLE: begin
                if (cpu_gnt) begin
                    state_d = S_ISSUE;
                    op_we_d = CPU_WE;
                end
            end
            S_ISSUE: state_d = S_LATCH;
            S_LATCH: begin
                if (!op_we_q)
                    cpu_dout_d = RAM_DOUT;
                ack_d   = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!CPU_CS) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q    <= S_IDLE;
            vpipe_q    <= 2'b00;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            ram_be_q   <= 2'b00;
            op_we_q    <= 1'b0;
            cpu_dout_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vpipe_q    <= vpipe_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            ram_be_q   <= ram_be_d;
            op_we_q    <= op_we_d;
            cpu_dout_q <= cpu_dout_d;
            ack_q      <= ack_d;
        end
    end

    assign REN_GNT   = ren_acc;
    assign REN_VALID = vpipe_q[1];
    assign REN_DATA  = RAM_DOUT;
    assign CPU_DOUT  = cpu_dout_q;
    assign CPU_ACK   = ack_q;
    assign RAM_ADDR  = ram_addr_q;
    assign RAM_DIN   = ram_din_q;
    assign RAM_WE    = ram_we_q;
    assign RAM_BE    = ram_be_q;

endmodule
`default_nettype wire
